uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit-side arbitration logic.
//   - UART_BYTE_W            : width of one serialised byte
//   - arb_state_t            : arbiter state encoding (IDLE / XFER)
//   - DEFAULT_TIMEOUT_CYCLES : default stall limit, 100 ms at 12 MHz
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1200000;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req upward starting one
//   position above last_winner, wrapping modulo NUM_REQ, and returns the
//   first set bit both as a one-hot vector and as a binary index.
//   Outputs are all zero when req is empty.
//
// Ports:
//   req         in  NUM_REQ  request vector
//   last_winner in  IDX_W    index that won most recently
//   onehot      out NUM_REQ  one-hot winner (zero if no request)
//   index       out IDX_W    binary winner index (zero if no request)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        cand   = '0;
        // Offsets 1..NUM_REQ visit every requester once, last_winner last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_winner) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found         = 1'b1;
                onehot[cand]  = 1'b1;
                index         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART TX byte path between NUM_REQ requesters using
//   packet-atomic round-robin arbitration. A grant is held until the
//   owner's last-flagged byte is accepted. All transfers are gated by the
//   host's CTS# line after a SYNC_STAGES-deep synchroniser.
//
//   Optional feature, macro UART_TX_ARB_TIMEOUT_EN: a stalled owner is
//   forcibly released after TIMEOUT_CYCLES cycles without progress while
//   the host is clear to send; timeout pulses for one cycle. Without the
//   macro timeout is tied low and grants are held indefinitely.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   req_valid  in   [NUM_REQ]    per-requester byte valid
//   req_data   in   [8*NUM_REQ]  per-requester byte, requester i at [8i+:8]
//   req_last   in   [NUM_REQ]    final byte of requester i's packet
//   req_ready  out  [NUM_REQ]    byte accepted from requester i
//   cts_n      in   host clear-to-send (async, low = may send)
//   tx_valid   out  byte offered to the serialiser
//   tx_data    out  [8] byte to serialise
//   tx_ready   in   serialiser accepts tx_data
//   grant      out  [NUM_REQ]    one-hot owner, zero when idle
//   busy       out  high while a packet is in progress
//   timeout    out  one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           cts_n,
    output logic                           tx_valid,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || SYNC_STAGES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
            $error("uart_tx_arbiter: unsupported parameter combination");
        end
    endgenerate

    arb_state_t             state;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       last_winner;
    logic [SYNC_STAGES-1:0] cts_sync;
    logic                   cts_ok;
    logic                   in_xfer;
    logic                   xfer;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]       pick_index;
    logic [UART_BYTE_W-1:0] req_byte [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_split
            assign req_byte[gi] = req_data[UART_BYTE_W*gi +: UART_BYTE_W];
        end
    endgenerate

    // Synchroniser resets to "not clear" so nothing moves until the host
    // has been seen low through every stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cts_sync <= '1;
        end else begin
            cts_sync[0] <= cts_n;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                cts_sync[s] <= cts_sync[s-1];
            end
        end
    end

    assign cts_ok = ~cts_sync[SYNC_STAGES-1];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (req_valid),
        .last_winner (last_winner),
        .onehot      (pick_onehot),
        .index       (pick_index)
    );

    // Byte path is steered by registered state/owner only; tx_ready never
    // feeds back into tx_valid.
    assign in_xfer  = (state == XFER);
    assign busy     = in_xfer;
    assign tx_valid = in_xfer & req_valid[owner] & cts_ok;
    assign tx_data  = in_xfer ? req_byte[owner] : '0;
    assign xfer     = tx_valid & tx_ready;

    always_comb begin
        req_ready = '0;
        if (in_xfer) begin
            req_ready[owner] = tx_ready & cts_ok;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_expired;

    // Only cycles where the host is clear count as a stall.
    assign stall_expired = in_xfer & ~xfer & cts_ok &
                           (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
            stall_cnt   <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state <= XFER;
                        grant <= pick_onehot;
                        owner <= pick_index;
                    end
                end
                XFER: begin
                    if (xfer && req_last[owner]) begin
                        state       <= IDLE;
                        grant       <= '0;
                        last_winner <= owner;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (stall_expired) begin
                        state       <= IDLE;
                        grant       <= '0;
                        last_winner <= owner;
                        timeout     <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (!in_xfer || xfer || stall_expired) begin
                stall_cnt <= '0;
            end else if (cts_ok) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. Requesters are modelled as
//   byte queues; a behavioural reference tracks the current owner, the
//   round-robin pointer and the delayed view of CTS# and predicts every
//   output each cycle. Directed scenarios add explicit expectations.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int S = 2;
    localparam int T = 16;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int EXP_TO = 1;
`else
    localparam int EXP_TO = 0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           cts_n;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .cts_n     (cts_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    int errors = 0;
    int checks = 0;

    // Requester packets: {last, data}
    logic [8:0]   pq [N][$];
    logic [N-1:0] en;

    // Reference model
    int   m_owner;
    int   m_last;
    int   m_stall;
    bit   m_pulse;
    logic h [$];

    // Logs
    logic [7:0]   dlog [$];
    int           olog [$];
    logic [N-1:0] glog [$];
    int           to_count;
    logic         obs_txv;
    logic         obs_busy;
    logic [N-1:0] obs_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_stall = 0;
        m_pulse = 0;
        h.delete();
        for (int i = 0; i < S; i++) h.push_back(1'b1);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                {req_last[i], req_data[8*i +: 8]} = pq[i][0];
                req_valid[i] = en[i];
            end else begin
                req_last[i]        = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_valid[i]       = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        dlog.delete();
        olog.delete();
        glog.delete();
        to_count = 0;
    endtask

    // One clock cycle: drive, predict and compare, then advance model.
    task automatic cycle();
        logic         ok;
        logic         exp_txv;
        logic [7:0]   exp_d;
        logic [N-1:0] exp_rdy;
        logic         do_xfer;
        logic [8:0]   e;
        drive();
        #1;
        obs_txv   = tx_valid;
        obs_busy  = busy;
        obs_grant = grant;
        glog.push_back(grant);
        if (timeout === 1'b1) to_count++;
        ok      = !h[0];
        exp_txv = 1'b0;
        exp_d   = 8'h00;
        exp_rdy = '0;
        do_xfer = 1'b0;
        if (reset) begin
            if (m_owner >= 0) begin
                exp_txv          = req_valid[m_owner] & ok;
                exp_d            = (pq[m_owner].size() > 0) ? pq[m_owner][0][7:0] : 8'h00;
                exp_rdy[m_owner] = tx_ready & ok;
            end
            check("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("busy", busy, (m_owner >= 0) ? 32'd1 : 32'd0);
            check("tx_valid", tx_valid, exp_txv);
            check("tx_data", tx_data, exp_d);
            check("req_ready", req_ready, exp_rdy);
            check("timeout", timeout, m_pulse);
            do_xfer = exp_txv & tx_ready;
            if (do_xfer) begin
                dlog.push_back(exp_d);
                olog.push_back(m_owner);
            end
        end
        if (!reset) begin
            model_reset();
        end else begin
            m_pulse = 0;
            if (m_owner < 0) begin
                if (|req_valid) m_owner = rr_next(m_last, req_valid);
            end else if (do_xfer) begin
                e = pq[m_owner].pop_front();
                m_stall = 0;
                if (e[8]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (ok) begin
                if (m_stall == T - 1) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_stall = 0;
                    m_pulse = 1;
                end else begin
                    m_stall++;
                end
            end
`endif
            void'(h.pop_front());
            h.push_back(cts_n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_tx(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (dlog.size() < n && c < budget) begin
            cycle();
            c++;
        end
        check({tag, "_bytes_in_budget"}, (dlog.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        logic [N-1:0] e1 [6];
        logic [7:0]   bytes;
        int           r;
        int           len;

        e1 = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        reset     = 1'b0;
        en        = '0;
        cts_n     = 1'b1;
        tx_ready  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        model_reset();
        clear_logs();
        @(posedge clk);
        #1;
        cycles(2);

        // Reset state
        drive();
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_timeout", timeout, 0);
        reset    = 1'b1;
        cts_n    = 1'b0;
        tx_ready = 1'b1;
        cycles(3);

        // T1: 3-byte packet from requester 0
        clear_logs();
        pq[0].push_back(9'h041);
        pq[0].push_back(9'h042);
        pq[0].push_back(9'h143);
        en = 4'b0001;
        cycles(6);
        for (int i = 0; i < 6; i++) check($sformatf("t1_grant_c%0d", i), glog[i], e1[i]);
        check("t1_nbytes", dlog.size(), 3);
        check("t1_b0", dlog[0], 8'h41);
        check("t1_b1", dlog[1], 8'h42);
        check("t1_b2", dlog[2], 8'h43);

        // T2: all four single-byte packets, then requester 0 again
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycles(3);
        clear_logs();
        for (int i = 0; i < N; i++) pq[i].push_back(9'h1A0 + 9'(i));
        en = 4'b1111;
        run_until_tx(4, 30, "t2a");
        pq[0].push_back(9'h1A4);
        run_until_tx(5, 10, "t2b");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_owner%0d", i), olog[i], i % N);
            check($sformatf("t2_byte%0d", i), dlog[i], 8'hA0 + 8'(i));
        end

        // T3: host deasserts CTS mid-packet
        clear_logs();
        pq[1].push_back(9'h010);
        pq[1].push_back(9'h111);
        en = 4'b0010;
        run_until_tx(1, 10, "t3a");
        tx_ready = 1'b0;
        cts_n    = 1'b1;
        cycles(S);
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check($sformatf("t3_stall_txv%0d", i), obs_txv, 0);
            check($sformatf("t3_stall_grant%0d", i), obs_grant, 4'b0010);
        end
        check("t3_nbytes_stalled", dlog.size(), 1);
        cts_n = 1'b0;
        run_until_tx(2, 10, "t3b");
        cycles(3);
        check("t3_nbytes", dlog.size(), 2);
        check("t3_b1", dlog[1], 8'h11);

        // T4: owner 2 drops valid mid-packet while requester 1 waits
        clear_logs();
        pq[2].push_back(9'h020);
        pq[2].push_back(9'h021);
        pq[2].push_back(9'h122);
        pq[1].push_back(9'h130);
        en = 4'b0110;
        run_until_tx(1, 10, "t4a");
        en = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("t4_hold_grant%0d", i), obs_grant, 4'b0100);
        end
        check("t4_nbytes_hold", dlog.size(), 1);
        en = 4'b0110;
        run_until_tx(4, 20, "t4b");
        for (int i = 0; i < 4; i++) check($sformatf("t4_owner%0d", i), olog[i], (i < 3) ? 2 : 1);
        check("t4_b2", dlog[2], 8'h22);
        check("t4_b3", dlog[3], 8'h30);

        // T5: reset in the middle of requester 3's packet
        clear_logs();
        pq[3].push_back(9'h050);
        pq[3].push_back(9'h051);
        pq[3].push_back(9'h152);
        en = 4'b1000;
        run_until_tx(1, 10, "t5a");
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        pq[0].push_back(9'h160);
        pq[3].push_back(9'h170);
        en = 4'b1001;
        cycle();
        check("t5_post_grant", obs_grant, 0);
        check("t5_post_busy", obs_busy, 0);
        check("t5_post_txv", obs_txv, 0);
        run_until_tx(3, 20, "t5b");
        check("t5_first_owner", olog[1], 0);
        check("t5_second_owner", olog[2], 3);
        check("t5_b1", dlog[1], 8'h60);
        check("t5_b2", dlog[2], 8'h70);

        // T6: randomized traffic, back-pressure and CTS toggling
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7) == 0) begin
                r = $urandom_range(N - 1);
                if (pq[r].size() < 8) begin
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) begin
                        bytes = 8'($urandom);
                        pq[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, bytes});
                    end
                end
            end
            tx_ready = ($urandom_range(3) != 0);
            if ($urandom_range(19) == 0) cts_n = ~cts_n;
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(9) != 0);
            cycle();
        end
        en       = 4'b1111;
        cts_n    = 1'b0;
        tx_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() == 0) break;
            cycle();
        end
        check("t6_drained", pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size(), 0);
        cycles(3);

        // T7: owner stall with host clear, then stall from host back-pressure
        clear_logs();
        pq[0].push_back(9'h080);
        pq[0].push_back(9'h181);
        en = 4'b0001;
        run_until_tx(1, 10, "t7a");
        en = 4'b0000;
        cycles(20);
        check("t7_timeout_pulses", to_count, EXP_TO);
        check("t7_grant_after_stall", obs_grant, (EXP_TO == 1) ? 32'd0 : 32'd1);
        en = 4'b0001;
        run_until_tx(2, 10, "t7b");
        check("t7_b1", dlog[1], 8'h81);
        pq[1].push_back(9'h090);
        pq[1].push_back(9'h191);
        en = 4'b0010;
        run_until_tx(3, 10, "t7c");
        to_count = 0;
        tx_ready = 1'b0;
        cts_n    = 1'b1;
        cycles(S);
        tx_ready = 1'b1;
        cycles(100);
        check("t7_cts_no_timeout", to_count, 0);
        check("t7_cts_grant_held", obs_grant, 4'b0010);
        cts_n = 1'b0;
        run_until_tx(4, 10, "t7d");
        check("t7_b3", dlog[3], 8'h91);
        cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
